// File: rtl/qfmt_pkg.sv
// Shared Q-format definitions. The two's-complement encoder and the
// sign-magnitude converter both import this package.
`timescale 1ns/1ps

package qfmt_pkg;

   // Default sign-magnitude word width: sign bit plus N-1 magnitude bits.
   localparam int unsigned QFMT_N = 32;

   // Default number of fractional bits. The value only labels the format;
   // nothing in the datapath rescales by it.
   localparam int unsigned QFMT_Q = 15;

   // Largest magnitude that an n-bit sign-magnitude word can hold (2^(n-1)-1).
   // Valid for n up to 64.
   function automatic logic [63:0] qfmt_sat_mag(input int unsigned n);
      return (64'd1 << (n - 1)) - 64'd1;
   endfunction

   // Saturation magnitude for the default format.
   localparam logic [63:0] QFMT_SAT_MAG = qfmt_sat_mag(QFMT_N);

endpackage

// File: rtl/qtwos_abs.sv
// Combinational absolute value of a two's-complement word. Returns the sign
// and a magnitude as wide as the input. The magnitude is wide enough that the
// most negative input yields 2^(W-1) instead of wrapping.
`timescale 1ns/1ps

module qtwos_abs #(
   parameter int unsigned W = 64
) (
   input  logic [W-1:0] din,
   output logic         sign,
   output logic [W-1:0] mag
);

   assign sign = din[W-1];

   // For negative inputs, negating with ~x+1 gives 2^(W-1) when x is the most
   // negative value. Read as unsigned, that result is exactly |x|.
   assign mag = sign ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/qtwos_to_signmag.sv
// Two-stage converter from 2N-bit two's-complement Q-format to N-bit
// sign-magnitude Q-format, with saturation.
// Stage 1 registers the sign and the full-width magnitude.
// Stage 2 saturates the magnitude into N-1 bits and drives the output.
// Both ends use a valid/ready handshake.
// ovf_count counts the saturated words delivered downstream.
`timescale 1ns/1ps

module qtwos_to_signmag
   import qfmt_pkg::*;
#(
   parameter int unsigned N = QFMT_N,
   parameter int unsigned Q = QFMT_Q
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [2*N-1:0] in_data,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [N-1:0]   out_data,
   output logic           out_ovf,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [15:0]    ovf_count,
   input  logic           ovf_clr
);

   // The default format takes the shared constant that the encoder also uses.
   localparam logic [63:0]  SAT_FULL = (N == QFMT_N) ? QFMT_SAT_MAG : qfmt_sat_mag(N);
   localparam logic [N-2:0] MAG_MAX  = SAT_FULL[N-2:0];

   // The fractional-bit count cannot exceed the number of magnitude bits.
   if (Q > N - 1) begin : g_q_check
      $error("qtwos_to_signmag: Q exceeds the number of magnitude bits");
   end

   logic           abs_sign;
   logic [2*N-1:0] abs_mag;

   logic           s1_valid;
   logic           s1_sign;
   logic [2*N-1:0] s1_mag;
   logic           s2_valid;

   logic           s1_advance;
   logic           s1_load;
   logic           s2_advance;

   logic [N-1:0]   sat_data;
   logic           sat_ovf;
   logic           ovf_xfer;

   qtwos_abs #(.W(2*N)) u_abs (
      .din  (in_data),
      .sign (abs_sign),
      .mag  (abs_mag)
   );

   // Each stage moves forward when it is empty or its successor is moving.
   assign s2_advance = !s2_valid || out_ready;
   assign s1_advance = s1_valid && s2_advance;
   assign s1_load    = !s1_valid || s1_advance;

   // Reset is gated in so that in_ready reads 0 while the block is held in reset.
   assign in_ready   = rst_n && s1_load;
   assign out_valid  = s2_valid;
   assign ovf_xfer   = s2_valid && out_ready && out_ovf;

   // Stage 1: capture the sign and the full-width magnitude of each accepted word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: state updates use <= so that every flop samples pre-edge values.
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_mag   <= '0;
      end else if (s1_load) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign <= abs_sign;
            s1_mag  <= abs_mag;
         end
      end
   end

   // Saturate the magnitude into N-1 bits. A zero magnitude is always positive.
   always_comb begin
      // NOTE: every output gets a default first so that no path leaves one unassigned (no latch).
      sat_data        = '0;
      sat_ovf         = |s1_mag[2*N-1:N-1];
      sat_data[N-1]   = s1_sign && (s1_mag != '0);
      sat_data[N-2:0] = sat_ovf ? MAG_MAX : s1_mag[N-2:0];
   end

   // Stage 2: output register. It holds its value while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         out_data <= '0;
         out_ovf  <= 1'b0;
      end else if (s2_advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= sat_data;
            out_ovf  <= sat_ovf;
         end
      end
   end

   // Count saturated words as they are delivered. The count sticks at all-ones.
   // A clear in the same cycle as an overflow transfer leaves the count at 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_count <= '0;
      end else if (ovf_clr) begin
         ovf_count <= ovf_xfer ? 16'd1 : 16'd0;
      end else if (ovf_xfer && (ovf_count != 16'hFFFF)) begin
         ovf_count <= ovf_count + 16'd1;
      end
   end

endmodule

// File: doc/qtwos_to_signmag.md
QTWOS_TO_SIGNMAG -- requirements
Module: qtwos_to_signmag

Interface
REQ-001 SHALL have parameter N, default 32: width of the sign-magnitude Q-format output word (sign bit plus N-1 magnitude bits).
REQ-002 SHALL have parameter Q, default 15: number of fractional bits; carried through unchanged, no scaling applied.
REQ-003 SHALL have port clk  input  1: single clock; all state on the rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_data  input  2N: two's-complement Q-format value, same LSB weight as the output.
REQ-006 SHALL have port in_valid  input  1: in_data is valid this cycle.
REQ-007 SHALL have port in_ready  output  1: block accepts in_data this cycle.
REQ-008 SHALL have port out_data  output  N: bit N-1 is the sign; bits N-2:0 are the magnitude.
REQ-009 SHALL have port out_ovf  output  1: out_data was saturated; qualified by out_valid.
REQ-010 SHALL have port out_valid  output  1: out_data and out_ovf are valid.
REQ-011 SHALL have port out_ready  input  1: downstream accepts out_data this cycle.
REQ-012 SHALL have port ovf_count  output  16: number of saturated words delivered since reset.
REQ-013 SHALL have port ovf_clr  input  1: synchronous clear of ovf_count.

Function
REQ-014 A transfer SHALL occur on a clock edge where valid and ready are both high, at each end independently.
REQ-015 The pipeline SHALL have two register stages; latency from input transfer to out_valid SHALL be 2 cycles with out_ready held high.
REQ-016 Stage 1 SHALL register sign = in_data[2N-1] and a 2N-bit magnitude: in_data if sign=0, (~in_data)+1 if sign=1.
REQ-017 Stage 2 SHALL saturate: a magnitude of 2^(N-1) or more SHALL give a magnitude field of all ones (2^(N-1)-1) and out_ovf=1; otherwise the low N-1 bits with out_ovf=0.
REQ-018 The most negative input (only bit 2N-1 set) SHALL give a magnitude of 2^(2N-1) and SHALL saturate, with sign 1.
REQ-019 A zero magnitude SHALL always give sign 0; negative zero SHALL never appear on the output.
REQ-020 Each stage SHALL advance when it is empty or the next stage is advancing: in_ready = !s1_valid || s1_advance, and s2 advances when !out_valid || out_ready.
REQ-021 While backpressured (out_valid=1, out_ready=0), out_data and out_ovf SHALL hold stable and no word SHALL be dropped or duplicated.
REQ-022 Outputs SHALL appear in input order, and the pipeline SHALL sustain one word per cycle when out_ready=1.
REQ-023 ovf_count SHALL increment by 1 on each output transfer with out_ovf=1 and SHALL saturate at 16'hFFFF.
REQ-024 If ovf_clr and an overflow transfer occur in the same cycle, ovf_count SHALL become 1.

Reset
REQ-025 rst_n low SHALL immediately clear s1_valid, s2_valid, out_valid, out_ovf, out_data (to 0) and ovf_count (to 0).
REQ-026 in_ready SHALL be 0 while rst_n is low, and SHALL be 1 in the first cycle after release.
REQ-027 Words in flight when reset asserts SHALL be discarded; nothing from before reset SHALL appear on the output after it.

Structure
REQ-028 N and Q defaults, and the saturation magnitude constant, SHALL live in a shared package qfmt_pkg, shared with the existing two's-complement encoder.
REQ-029 The negate/abs datapath SHALL be a sub-module qtwos_abs (combinational, 2N-bit in, sign plus 2N-bit magnitude out); stage registers and handshake stay in the top module.

Verification
REQ-030 Send in_data 64'h0000_0000_0000_8000 (+1.0) with out_ready=1 -> 2 cycles later: out_data 32'h0000_8000, out_ovf 0.
REQ-031 Send 64'hFFFF_FFFF_FFFF_8000 (-1.0) -> out_data 32'h8000_8000, out_ovf 0; send 64'h0 -> out_data 32'h0000_0000.
REQ-032 Send 64'h0000_0000_8000_0000, then 64'h8000_0000_0000_0000 -> out_data 32'h7FFF_FFFF ovf 1, then 32'hFFFF_FFFF ovf 1; ovf_count reads 2.
REQ-033 Stream 4 words with out_ready=0 for 6 cycles -> in_ready drops after 2 accepted, outputs hold stable, all 4 words delivered in order after release.
REQ-034 Assert rst_n low with 2 words in flight -> out_valid 0 immediately; no stale word after release; ovf_count 0.
REQ-035 ovf_clr in the same cycle as an overflow transfer -> ovf_count 1; 65536 overflow transfers -> ovf_count holds at 16'hFFFF.
